apb_cmd_queue: RTL and testbench
================================

// Module: apb_cmd_queue
// PURPOSE
//  Upstream command stage for the APB master interface. Buffers host read/write commands in a FIFO.
//  Issues them one at a time on the master's address/process/data_size/write_data inputs.
//  Monitors PSEL/PENABLE/PREADY for completion. Returns one response (read data or write ack, with error flag) per command.
// PARAMETERS
//  ADDR_W   32  address width (matches PADDR)
//  DATA_W   32  data width (matches PWDATA/PRDATA)
//  DEPTH     4  command FIFO entries, power of 2, >=2
//  TIMEOUT  16  max cycles in DRIVE before abort, >=2
// PORTS
//  clk          in   1        single clock (same clock as PCLK)
//  rst          in   1        synchronous reset, active-high
//  cmd_valid    in   1        host command valid
//  cmd_ready    out  1        = !fifo_full
//  cmd_write    in   1        1 write, 0 read
//  cmd_addr     in   ADDR_W   byte address
//  cmd_size     in   2        00 byte, 01 half, 10 word, 11 illegal
//  cmd_wdata    in   DATA_W   write data
//  address      out  ADDR_W   to master address
//  process      out  2        to master process: 00 IDLE, 01 READ, 10 WRITE
//  data_size    out  2        to master data_size
//  write_data   out  DATA_W   to master write_data
//  read_data    in   DATA_W   from master read_data
//  mon_psel     in   1        PSEL0|PSEL1
//  mon_penable  in   1        PENABLE
//  mon_pready   in   1        PREADY
//  rsp_valid    out  1        response valid, held until rsp_ready
//  rsp_ready    in   1        host accepts response
//  rsp_write    out  1        response belongs to a write
//  rsp_rdata    out  DATA_W   read data; 0 for writes and errors
//  rsp_err      out  1        1 = illegal size, misaligned or timeout
// BEHAVIOUR
//  - Reset (rst=1 at edge): FIFO emptied, state IDLE, process=00, address/data_size/write_data=0, rsp_*=0, cmd_ready=1 next cycle.
//    Applies mid-transfer too; in-flight command and pending response are lost.
//  - FIFO push: cmd_valid & cmd_ready. Full => cmd_ready=0 even if a pop occurs the same cycle.
//  - FIFO is first-word-fall-through. Pop happens only in IDLE.
//  - FSM, all outputs registered:
//    IDLE: if !empty & !rsp_valid: pop head, check it.
//      - size==11, or misaligned (half: addr[0]!=0; word: addr[1:0]!=0) => load error response (rsp_err=1), stay IDLE. No APB transfer.
//      - else load address/data_size/write_data, process=READ|WRITE, -> DRIVE.
//    DRIVE: done = mon_psel & mon_penable & mon_pready.
//      - On done: process=00; write -> RESP (ack, err=0); read -> CAPTURE.
//      - Timer counts DRIVE cycles from 0. If it reaches TIMEOUT-1 with no done: process=00, err response, -> IDLE.
//    CAPTURE: one cycle; rsp_rdata<=read_data (master registers PRDATA at done edge); rsp_valid<=1; -> IDLE.
//    RESP: rsp_valid<=1 for write ack, -> IDLE. May be merged into the done edge, provided the latency below holds.
//  - Latency, no backpressure, slave PREADY=1 in the access phase:
//    cmd accepted cycle N; process!=00 from N+2; write rsp_valid at N+5; read rsp_valid at N+6.
//  - Exactly one command outstanding. Next pop waits until the response is consumed (rsp_valid & rsp_ready) and the FSM is in IDLE.
//  - rsp_* stable while rsp_valid & !rsp_ready.
//  - Pointers wrap modulo DEPTH. Count is $clog2(DEPTH)+1 bits. No overflow/underflow possible by construction.
// STRUCTURE
//  - apb_cmd_pkg: process_e {P_IDLE,P_READ,P_WRITE}, size_e {SZ_BYTE,SZ_HALF,SZ_WORD}, state_e {IDLE,DRIVE,CAPTURE,RESP},
//    cmd_t packed struct {write,addr,size,wdata}, function is_aligned(addr,size).
//  - Sub-module apb_sync_fifo #(WIDTH=$bits(cmd_t), DEPTH): FWFT sync FIFO with full/empty; clk, rst as above.
// TESTING
//  1. Write addr=0x10 size=10 data=0xDEADBEEF, slave ready -> one APB write; rsp_valid at N+5, rsp_write=1, err=0.
//  2. Read addr=0x10 after test 1 -> rsp_rdata=0xDEADBEEF, rsp_write=0, err=0, rsp_valid at N+6.
//  3. Push 5 cmds back-to-back with DEPTH=4, rsp_ready=0 -> cmd_ready drops once FIFO holds 4;
//     draining responses issues all in order, no loss or duplication.
//  4. cmd_size=11, then word read addr=0x2 -> two err responses, process stays 00, no PSEL.
//  5. Slave holds PREADY=0 -> process returns 00 after TIMEOUT cycles in DRIVE; rsp_err=1; next command proceeds normally.
//  6. rst=1 during DRIVE with 2 queued cmds -> next cycle process=00, rsp_valid=0, cmd_ready=1, FIFO empty.

Source files
------------

// File: rtl/apb_cmd_pkg.sv
// Shared types and helpers for the APB command queue.
//   process_e : command code driven to the APB master (IDLE/READ/WRITE)
//   size_e    : legal transfer sizes (2'b11 is the illegal encoding)
//   state_e   : sequencing states of the command issue FSM
//   cmd_t     : one buffered host command as stored in the FIFO
//   is_aligned: natural-alignment check of an address for a given size
package apb_cmd_pkg;

   localparam int CMD_ADDR_W = 32;
   localparam int CMD_DATA_W = 32;

   typedef enum logic [1:0] {
      P_IDLE  = 2'b00,
      P_READ  = 2'b01,
      P_WRITE = 2'b10
   } process_e;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'b00,
      SZ_HALF = 2'b01,
      SZ_WORD = 2'b10
   } size_e;

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      DRIVE   = 2'b01,
      CAPTURE = 2'b10,
      RESP    = 2'b11
   } state_e;

   typedef struct packed {
      logic                  write;
      logic [CMD_ADDR_W-1:0] addr;
      logic [1:0]            size;
      logic [CMD_DATA_W-1:0] wdata;
   } cmd_t;

   // Only the two low address bits matter for natural alignment.
   function automatic logic is_aligned(input logic [1:0] addr_lo, input logic [1:0] size);
      logic ok_s;
      case (size)
         SZ_BYTE: ok_s = 1'b1;
         SZ_HALF: ok_s = (addr_lo[0] == 1'b0);
         SZ_WORD: ok_s = (addr_lo == 2'b00);
         default: ok_s = 1'b0;
      endcase
      return ok_s;
   endfunction

endpackage

// File: rtl/apb_sync_fifo.sv
// First-word-fall-through synchronous FIFO.
//   clk, rst     : clock, synchronous active-high reset
//   push, din    : write request and data (ignored when full)
//   pop          : consume head entry (ignored when empty)
//   dout         : current head entry, valid whenever !empty
//   full, empty  : occupancy flags derived from the registered count
module apb_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [PTR_W-1:0] wr_ptr_r;
   logic [PTR_W-1:0] rd_ptr_r;
   logic [CNT_W-1:0] count_r;
   logic             do_push_s;
   logic             do_pop_s;

   assign full      = (count_r == CNT_W'(DEPTH));
   assign empty     = (count_r == {CNT_W{1'b0}});
   assign do_push_s = push & ~full;
   assign do_pop_s  = pop & ~empty;
   assign dout      = mem_r[rd_ptr_r];

   // Storage array; data needs no reset because empty masks it.
   always_ff @(posedge clk) begin
      if (do_push_s) begin
         mem_r[wr_ptr_r] <= din;
      end
   end

   // Pointers wrap naturally at DEPTH (power of two); count tracks occupancy.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_r <= {PTR_W{1'b0}};
         rd_ptr_r <= {PTR_W{1'b0}};
         count_r  <= {CNT_W{1'b0}};
      end else begin
         if (do_push_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_W'(1);
         end
         if (do_pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_W'(1);
         end
         case ({do_push_s, do_pop_s})
            2'b10:   count_r <= count_r + CNT_W'(1);
            2'b01:   count_r <= count_r - CNT_W'(1);
            default: count_r <= count_r;
         endcase
      end
   end

endmodule

// File: rtl/apb_cmd_queue.sv
// Upstream command stage for the APB master: buffers host commands, issues
// them one at a time, watches PSEL/PENABLE/PREADY for completion and returns
// one response per command.
//   cmd_*       : host command channel (valid/ready)
//   address, process, data_size, write_data : registered master controls
//   read_data   : master's registered PRDATA
//   mon_*       : APB bus monitor inputs for completion detection
//   rsp_*       : host response channel (valid/ready), held until accepted
module apb_cmd_queue
   import apb_cmd_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [1:0]        cmd_size,
   input  logic [DATA_W-1:0] cmd_wdata,
   output logic [ADDR_W-1:0] address,
   output logic [1:0]        process,
   output logic [1:0]        data_size,
   output logic [DATA_W-1:0] write_data,
   input  logic [DATA_W-1:0] read_data,
   input  logic              mon_psel,
   input  logic              mon_penable,
   input  logic              mon_pready,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic              rsp_write,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err
);

   localparam int TMR_W = $clog2(TIMEOUT);
   localparam int CMD_W = $bits(cmd_t);

   cmd_t              push_cmd_s;
   cmd_t              head_s;
   logic [CMD_W-1:0]  fifo_dout_s;
   logic              fifo_full_s;
   logic              fifo_empty_s;
   logic              pop_s;
   logic              done_s;
   logic              head_ok_s;

   state_e            state_r,      state_nxt_s;
   logic [TMR_W-1:0]  timer_r,      timer_nxt_s;
   logic              cur_write_r,  cur_write_nxt_s;
   logic [1:0]        process_r,    process_nxt_s;
   logic [ADDR_W-1:0] address_r,    address_nxt_s;
   logic [1:0]        data_size_r,  data_size_nxt_s;
   logic [DATA_W-1:0] write_data_r, write_data_nxt_s;
   logic              rsp_valid_r,  rsp_valid_nxt_s;
   logic              rsp_write_r,  rsp_write_nxt_s;
   logic [DATA_W-1:0] rsp_rdata_r,  rsp_rdata_nxt_s;
   logic              rsp_err_r,    rsp_err_nxt_s;

   assign push_cmd_s = '{write: cmd_write, addr: cmd_addr, size: cmd_size, wdata: cmd_wdata};
   assign head_s     = cmd_t'(fifo_dout_s);
   assign cmd_ready  = ~fifo_full_s;
   assign done_s     = mon_psel & mon_penable & mon_pready;
   assign head_ok_s  = (head_s.size != 2'b11) && is_aligned(head_s.addr[1:0], head_s.size);

   apb_sync_fifo #(
      .WIDTH (CMD_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (cmd_valid),
      .din   (push_cmd_s),
      .pop   (pop_s),
      .dout  (fifo_dout_s),
      .full  (fifo_full_s),
      .empty (fifo_empty_s)
   );

   // Next-state and registered-output values of the issue FSM.
   always_comb begin
      state_nxt_s      = state_r;
      timer_nxt_s      = timer_r;
      cur_write_nxt_s  = cur_write_r;
      process_nxt_s    = process_r;
      address_nxt_s    = address_r;
      data_size_nxt_s  = data_size_r;
      write_data_nxt_s = write_data_r;
      rsp_write_nxt_s  = rsp_write_r;
      rsp_rdata_nxt_s  = rsp_rdata_r;
      rsp_err_nxt_s    = rsp_err_r;
      pop_s            = 1'b0;
      if (rsp_valid_r && rsp_ready) begin
         rsp_valid_nxt_s = 1'b0;
      end else begin
         rsp_valid_nxt_s = rsp_valid_r;
      end

      case (state_r)
         IDLE: begin
            // Pop only once the previous response has left, so at most one
            // command is ever outstanding.
            if (!fifo_empty_s && !rsp_valid_r) begin
               pop_s = 1'b1;
               if (!head_ok_s) begin
                  rsp_valid_nxt_s = 1'b1;
                  rsp_err_nxt_s   = 1'b1;
                  rsp_write_nxt_s = head_s.write;
                  rsp_rdata_nxt_s = {DATA_W{1'b0}};
               end else begin
                  address_nxt_s    = head_s.addr;
                  data_size_nxt_s  = head_s.size;
                  write_data_nxt_s = head_s.wdata;
                  process_nxt_s    = head_s.write ? P_WRITE : P_READ;
                  cur_write_nxt_s  = head_s.write;
                  timer_nxt_s      = {TMR_W{1'b0}};
                  state_nxt_s      = DRIVE;
               end
            end else begin
               pop_s = 1'b0;
            end
         end
         DRIVE: begin
            if (done_s) begin
               process_nxt_s = P_IDLE;
               if (cur_write_r) begin
                  // Write ack is folded into the completion edge.
                  rsp_valid_nxt_s = 1'b1;
                  rsp_write_nxt_s = 1'b1;
                  rsp_err_nxt_s   = 1'b0;
                  rsp_rdata_nxt_s = {DATA_W{1'b0}};
                  state_nxt_s     = IDLE;
               end else begin
                  state_nxt_s = CAPTURE;
               end
            end else if (timer_r == TMR_W'(TIMEOUT - 1)) begin
               process_nxt_s   = P_IDLE;
               rsp_valid_nxt_s = 1'b1;
               rsp_write_nxt_s = cur_write_r;
               rsp_err_nxt_s   = 1'b1;
               rsp_rdata_nxt_s = {DATA_W{1'b0}};
               state_nxt_s     = IDLE;
            end else begin
               timer_nxt_s = timer_r + TMR_W'(1);
            end
         end
         CAPTURE: begin
            // The master registered PRDATA on the completion edge.
            rsp_valid_nxt_s = 1'b1;
            rsp_write_nxt_s = 1'b0;
            rsp_err_nxt_s   = 1'b0;
            rsp_rdata_nxt_s = read_data;
            state_nxt_s     = IDLE;
         end
         RESP: begin
            rsp_valid_nxt_s = 1'b1;
            rsp_write_nxt_s = 1'b1;
            rsp_err_nxt_s   = 1'b0;
            rsp_rdata_nxt_s = {DATA_W{1'b0}};
            state_nxt_s     = IDLE;
         end
         default: begin
            process_nxt_s = P_IDLE;
            state_nxt_s   = IDLE;
         end
      endcase
   end

   // State and output registers; reset drops any in-flight command/response.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r      <= IDLE;
         timer_r      <= {TMR_W{1'b0}};
         cur_write_r  <= 1'b0;
         process_r    <= P_IDLE;
         address_r    <= {ADDR_W{1'b0}};
         data_size_r  <= 2'b00;
         write_data_r <= {DATA_W{1'b0}};
         rsp_valid_r  <= 1'b0;
         rsp_write_r  <= 1'b0;
         rsp_rdata_r  <= {DATA_W{1'b0}};
         rsp_err_r    <= 1'b0;
      end else begin
         state_r      <= state_nxt_s;
         timer_r      <= timer_nxt_s;
         cur_write_r  <= cur_write_nxt_s;
         process_r    <= process_nxt_s;
         address_r    <= address_nxt_s;
         data_size_r  <= data_size_nxt_s;
         write_data_r <= write_data_nxt_s;
         rsp_valid_r  <= rsp_valid_nxt_s;
         rsp_write_r  <= rsp_write_nxt_s;
         rsp_rdata_r  <= rsp_rdata_nxt_s;
         rsp_err_r    <= rsp_err_nxt_s;
      end
   end

   assign address    = address_r;
   assign process    = process_r;
   assign data_size  = data_size_r;
   assign write_data = write_data_r;
   assign rsp_valid  = rsp_valid_r;
   assign rsp_write  = rsp_write_r;
   assign rsp_rdata  = rsp_rdata_r;
   assign rsp_err    = rsp_err_r;

endmodule

// File: tb/tb_apb_cmd_queue.sv
// Directed bench for apb_cmd_queue with a behavioural APB master/slave model.
module tb_apb_cmd_queue;

   logic        clk = 1'b0;
   logic        rst, cmd_valid, cmd_ready, cmd_write;
   logic [31:0] cmd_addr, cmd_wdata, address, write_data, read_data, rsp_rdata;
   logic [1:0]  cmd_size, process, data_size;
   logic        mon_psel, mon_penable, mon_pready;
   logic        rsp_valid, rsp_ready, rsp_write, rsp_err;

   int          total = 0;
   int          bad = 0;
   int          xfer_cnt = 0;
   int          psel_cnt = 0;
   int          m = 0;
   logic        slave_ready = 1'b1;
   logic [1:0]  proc_seen = 2'b00;
   logic [31:0] addr_seen = 32'h0;
   logic [31:0] wdat_seen = 32'h0;
   logic [31:0] mem [16];

   always #5 clk = ~clk;

   apb_cmd_queue dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
      .address(address), .process(process), .data_size(data_size),
      .write_data(write_data), .read_data(read_data),
      .mon_psel(mon_psel), .mon_penable(mon_penable), .mon_pready(mon_pready),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
      .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
   );

   // Snapshot of the master-side controls during each cycle.
   initial begin
      forever begin
         @(negedge clk);
         proc_seen = process;
         addr_seen = address;
         wdat_seen = write_data;
      end
   end

   // Behavioural APB master + memory slave: setup one cycle after process
   // goes non-idle, access next, completes when PREADY was high.
   initial begin
      mon_psel = 1'b0; mon_penable = 1'b0; mon_pready = 1'b0; read_data = 32'h0;
      forever begin
         @(posedge clk); #1;
         case (m)
            0: if (proc_seen != 2'b00) begin
                  mon_psel = 1'b1; mon_penable = 1'b0; psel_cnt++; m = 1;
               end
            1: begin
                  mon_penable = 1'b1; mon_pready = slave_ready; m = 2;
               end
            2: if (mon_pready) begin
                  xfer_cnt++;
                  if (proc_seen == 2'b10) mem[addr_seen[5:2]] = wdat_seen;
                  else read_data = mem[addr_seen[5:2]];
                  mon_psel = 1'b0; mon_penable = 1'b0; mon_pready = 1'b0; m = 0;
               end else if (proc_seen == 2'b00) begin
                  mon_psel = 1'b0; mon_penable = 1'b0; m = 0;
               end
            default: m = 0;
         endcase
      end
   end

   task automatic push_cmd(input logic w, input logic [31:0] a, input logic [1:0] s, input logic [31:0] d);
      cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_size = s; cmd_wdata = d;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
   endtask

   task automatic consume();
      @(posedge clk); #1; rsp_ready = 1'b1;
      @(posedge clk); #1; rsp_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      total++; if (process !== 2'b00) begin bad++; $display("FAIL reset_process: got %0h want 0", process); end
      total++; if (address !== 32'h0) begin bad++; $display("FAIL reset_address: got %h want 0", address); end
      total++; if (data_size !== 2'b00 || write_data !== 32'h0) begin bad++; $display("FAIL reset_size_wdata: got %0h/%h want 0/0", data_size, write_data); end
      total++; if ({rsp_valid, rsp_write, rsp_err} !== 3'b000 || rsp_rdata !== 32'h0) begin bad++; $display("FAIL reset_rsp: got v%b w%b e%b d%h want all 0", rsp_valid, rsp_write, rsp_err, rsp_rdata); end
      total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready); end
      @(posedge clk); #1;
   endtask

   task automatic test_write();
      int x0 = xfer_cnt;
      push_cmd(1'b1, 32'h10, 2'b10, 32'hDEADBEEF);
      @(negedge clk);  // N+1
      total++; if (process !== 2'b00) begin bad++; $display("FAIL wr_proc_n1: got %0h want 0", process); end
      @(negedge clk);  // N+2
      total++; if (process !== 2'b10) begin bad++; $display("FAIL wr_proc_n2: got %0h want 2", process); end
      total++; if (address !== 32'h10 || data_size !== 2'b10 || write_data !== 32'hDEADBEEF) begin bad++; $display("FAIL wr_ctrl: got %h/%0h/%h want 10/2/deadbeef", address, data_size, write_data); end
      repeat (2) @(negedge clk);  // N+4
      total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL wr_rsp_early: got %b want 0", rsp_valid); end
      @(negedge clk);  // N+5
      total++; if (rsp_valid !== 1'b1 || rsp_write !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0) begin bad++; $display("FAIL wr_rsp: got v%b w%b e%b d%h want v1 w1 e0 d0", rsp_valid, rsp_write, rsp_err, rsp_rdata); end
      total++; if (mem[4] !== 32'hDEADBEEF || xfer_cnt - x0 != 1) begin bad++; $display("FAIL wr_bus: got mem %h xfers %0d want deadbeef 1", mem[4], xfer_cnt - x0); end
      repeat (3) @(negedge clk);
      total++; if (rsp_valid !== 1'b1 || rsp_write !== 1'b1 || rsp_err !== 1'b0) begin bad++; $display("FAIL wr_rsp_hold: got v%b w%b e%b want v1 w1 e0", rsp_valid, rsp_write, rsp_err); end
      consume();
      @(negedge clk);
      total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL wr_rsp_consumed: got %b want 0", rsp_valid); end
      @(posedge clk); #1;
   endtask

   task automatic test_read();
      push_cmd(1'b0, 32'h10, 2'b10, 32'h0);
      repeat (2) @(negedge clk);  // N+2
      total++; if (process !== 2'b01 || address !== 32'h10) begin bad++; $display("FAIL rd_proc: got %0h/%h want 1/10", process, address); end
      repeat (3) @(negedge clk);  // N+5
      total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rd_rsp_early: got %b want 0", rsp_valid); end
      @(negedge clk);  // N+6
      total++; if (rsp_valid !== 1'b1 || rsp_write !== 1'b0 || rsp_err !== 1'b0 || rsp_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL rd_rsp: got v%b w%b e%b d%h want v1 w0 e0 deadbeef", rsp_valid, rsp_write, rsp_err, rsp_rdata); end
      consume();
   endtask

   task automatic test_back_to_back();
      logic        w_tab [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
      logic [31:0] a_tab [5] = '{32'h20, 32'h24, 32'h20, 32'h24, 32'h28};
      logic [31:0] d_tab [5] = '{32'h11111111, 32'h22222222, 32'h0, 32'h0, 32'h33333333};
      logic [31:0] e_tab [5] = '{32'h0, 32'h0, 32'h11111111, 32'h22222222, 32'h0};
      int x0 = xfer_cnt;
      logic acc, got;
      rsp_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         cmd_valid = 1'b1; cmd_write = w_tab[i]; cmd_addr = a_tab[i]; cmd_size = 2'b10; cmd_wdata = d_tab[i];
         acc = 1'b0;
         for (int g = 0; g < 20 && !acc; g++) begin
            @(negedge clk); acc = cmd_ready;
            @(posedge clk); #1;
         end
         total++; if (!acc) begin bad++; $display("FAIL b2b_push%0d: got not accepted want accepted", i); end
      end
      cmd_valid = 1'b0;
      @(negedge clk);
      total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL b2b_full: got cmd_ready %b want 0", cmd_ready); end
      for (int i = 0; i < 5; i++) begin
         got = 1'b0;
         for (int g = 0; g < 40 && !got; g++) begin
            @(negedge clk); got = rsp_valid;
         end
         total++; if (!got) begin bad++; $display("FAIL b2b_rsp%0d_timeout: got no rsp_valid want rsp_valid", i); end
         total++; if (rsp_write !== w_tab[i] || rsp_rdata !== e_tab[i] || rsp_err !== 1'b0) begin bad++; $display("FAIL b2b_rsp%0d: got w%b d%h e%b want w%b d%h e0", i, rsp_write, rsp_rdata, rsp_err, w_tab[i], e_tab[i]); end
         consume();
      end
      repeat (10) @(negedge clk);
      total++; if (rsp_valid !== 1'b0 || xfer_cnt - x0 != 5) begin bad++; $display("FAIL b2b_count: got v%b xfers %0d want v0 5", rsp_valid, xfer_cnt - x0); end
      total++; if (mem[10] !== 32'h33333333 || cmd_ready !== 1'b1) begin bad++; $display("FAIL b2b_last: got mem %h rdy %b want 33333333 1", mem[10], cmd_ready); end
      @(posedge clk); #1;
   endtask

   task automatic test_errors();
      logic        w_tab [3] = '{1'b1, 1'b0, 1'b1};
      logic [31:0] a_tab [3] = '{32'h40, 32'h02, 32'h41};
      logic [1:0]  s_tab [3] = '{2'b11, 2'b10, 2'b01};
      int p0 = psel_cnt;
      for (int i = 0; i < 3; i++) begin
         push_cmd(w_tab[i], a_tab[i], s_tab[i], 32'hA5A5A5A5);
         @(negedge clk);  // N+1
         total++; if (rsp_valid !== 1'b0 || process !== 2'b00) begin bad++; $display("FAIL err%0d_n1: got v%b p%0h want v0 p0", i, rsp_valid, process); end
         @(negedge clk);  // N+2
         total++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_write !== w_tab[i] || rsp_rdata !== 32'h0 || process !== 2'b00) begin bad++; $display("FAIL err%0d_rsp: got v%b e%b w%b d%h p%0h want v1 e1 w%b d0 p0", i, rsp_valid, rsp_err, rsp_write, rsp_rdata, process, w_tab[i]); end
         consume();
      end
      repeat (3) @(negedge clk);
      total++; if (psel_cnt != p0) begin bad++; $display("FAIL err_no_psel: got %0d setups want 0", psel_cnt - p0); end
      @(posedge clk); #1;
   endtask

   task automatic test_timeout();
      slave_ready = 1'b0;
      push_cmd(1'b1, 32'h30, 2'b10, 32'h55AA55AA);
      repeat (2) @(negedge clk);  // N+2
      total++; if (process !== 2'b10) begin bad++; $display("FAIL to_start: got %0h want 2", process); end
      repeat (15) @(negedge clk);  // N+17
      total++; if (process !== 2'b10 || rsp_valid !== 1'b0) begin bad++; $display("FAIL to_before: got p%0h v%b want p2 v0", process, rsp_valid); end
      @(negedge clk);  // N+18
      total++; if (process !== 2'b00 || rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_write !== 1'b1 || rsp_rdata !== 32'h0) begin bad++; $display("FAIL to_abort: got p%0h v%b e%b w%b d%h want p0 v1 e1 w1 d0", process, rsp_valid, rsp_err, rsp_write, rsp_rdata); end
      total++; if (mem[12] !== 32'h0) begin bad++; $display("FAIL to_no_write: got %h want 0", mem[12]); end
      slave_ready = 1'b1;
      consume();
      push_cmd(1'b0, 32'h20, 2'b10, 32'h0);
      repeat (2) @(negedge clk);  // N+2
      total++; if (process !== 2'b01) begin bad++; $display("FAIL to_next_proc: got %0h want 1", process); end
      repeat (4) @(negedge clk);  // N+6
      total++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'h11111111) begin bad++; $display("FAIL to_next_rsp: got v%b e%b d%h want v1 e0 11111111", rsp_valid, rsp_err, rsp_rdata); end
      consume();
   endtask

   task automatic test_reset_mid();
      logic seen = 1'b0;
      slave_ready = 1'b0;
      push_cmd(1'b1, 32'h2C, 2'b10, 32'h44444444);
      push_cmd(1'b1, 32'h30, 2'b10, 32'h55555555);
      push_cmd(1'b0, 32'h20, 2'b10, 32'h0);
      @(negedge clk);
      total++; if (process !== 2'b10) begin bad++; $display("FAIL rm_drive: got %0h want 2", process); end
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      total++; if (process !== 2'b00 || rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || address !== 32'h0) begin bad++; $display("FAIL rm_after: got p%0h v%b r%b a%h want p0 v0 r1 a0", process, rsp_valid, cmd_ready, address); end
      slave_ready = 1'b1;
      for (int g = 0; g < 12; g++) begin
         @(negedge clk);
         if (process !== 2'b00 || rsp_valid !== 1'b0) seen = 1'b1;
      end
      total++; if (seen !== 1'b0) begin bad++; $display("FAIL rm_fifo_empty: got activity want none"); end
      @(posedge clk); #1;
      push_cmd(1'b1, 32'h2C, 2'b10, 32'h77777777);
      repeat (5) @(negedge clk);  // N+5
      total++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || mem[11] !== 32'h77777777) begin bad++; $display("FAIL rm_resume: got v%b e%b mem %h want v1 e0 77777777", rsp_valid, rsp_err, mem[11]); end
      consume();
   endtask

   initial begin
      rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 32'h0;
      cmd_size = 2'b00; cmd_wdata = 32'h0; rsp_ready = 1'b0;
      for (int i = 0; i < 16; i++) mem[i] = 32'h0;
      test_reset();
      test_write();
      test_read();
      test_back_to_back();
      test_errors();
      test_timeout();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
